// File: rtl/nn_pkg.sv
// ============================================================================
// Module      : nn_pkg
// Description : Shared constants, FSM encoding and saturation helper for the
//               dense neuron stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nn_pkg;

  localparam int DW_DEFAULT   = 8;
  localparam int FRAC_DEFAULT = 4;

  localparam int ACT_RELU  = 0;
  localparam int ACT_IDENT = 1;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_MAC     = 3'd1,
    ST_BIAS    = 3'd2,
    ST_ACT     = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

  // Clamp to [0, 2^(dw-1)-1] when relu is set, else to the signed dw range.
  function automatic logic signed [31:0] sat_to_dw(input logic signed [31:0] v,
                                                   input int dw,
                                                   input logic relu);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = relu ? 32'sd0 : -(32'sd1 <<< (dw - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nn_mac_unit.sv
// ============================================================================
// Module      : nn_mac_unit
// Description : Single signed MAC: floor-scaled product or raw bias added to a
//               wrapping accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_mac_unit #(
  parameter int DW    = 8,
  parameter int FRAC  = 4,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    bias_sel,
  input  logic signed [DW-1:0]    x,
  input  logic signed [DW-1:0]    w,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [2*DW-1:0]  w_shift;
  logic signed [ACC_W-1:0] w_term;

  // In bias mode w carries the bias, which is already in the accumulator's Q format.
  always_comb begin
    w_prod  = (2*DW)'(x) * (2*DW)'(w);
    w_shift = w_prod >>> FRAC;
    w_term  = bias_sel ? ACC_W'(w) : ACC_W'(w_shift);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= acc + w_term;
  end

endmodule

`default_nettype wire

// File: rtl/nn_dense_stage.sv
// ============================================================================
// Module      : nn_dense_stage
// Description : Serial fully-connected stage: collect N_IN activations, then
//               compute and emit N_OUT neurons through one shared MAC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_dense_stage
  import nn_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int DW    = DW_DEFAULT,
  parameter int FRAC  = FRAC_DEFAULT,
  parameter int ACC_W = 20,
  parameter int ACT   = ACT_RELU,
  localparam int c_IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int c_AW    = $clog2(N_OUT*N_IN + N_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DW-1:0]      in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [c_IDX_W-1:0] out_idx,
  output logic               out_last,
  input  logic               out_ready,
  input  logic               cfg_we,
  input  logic [c_AW-1:0]    cfg_addr,
  input  logic [DW-1:0]      cfg_data,
  output logic               busy
);

  localparam int c_CW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [c_AW:0]      c_NW_X     = (c_AW+1)'(N_OUT*N_IN);
  localparam logic [c_AW:0]      c_NP_X     = (c_AW+1)'(N_OUT*N_IN + N_OUT);
  localparam logic [c_AW-1:0]    c_NW_S     = c_AW'(N_OUT*N_IN);
  localparam logic [c_CW-1:0]    c_CNT_LAST = c_CW'(N_IN - 1);
  localparam logic [c_IDX_W-1:0] c_J_LAST   = c_IDX_W'(N_OUT - 1);

  state_t               r_state;
  logic [c_CW-1:0]      r_cnt;
  logic [c_IDX_W-1:0]   r_j;
  logic [c_AW-1:0]      r_wa;
  logic signed [DW-1:0] r_x [2**c_CW];
  logic signed [DW-1:0] r_w [2**c_AW];
  logic signed [DW-1:0] r_b [2**c_IDX_W];

  logic                    w_accept;
  logic                    w_is_w;
  logic                    w_is_b;
  logic                    w_mac_en;
  logic                    w_mac_clr;
  logic                    w_bias_sel;
  logic signed [DW-1:0]    w_mac_w;
  logic signed [ACC_W-1:0] w_acc;

  always_comb begin
    w_accept   = (r_state == ST_COLLECT) && in_valid;
    w_is_w     = {1'b0, cfg_addr} < c_NW_X;
    w_is_b     = !w_is_w && ({1'b0, cfg_addr} < c_NP_X);
    w_mac_en   = (r_state == ST_MAC) || (r_state == ST_BIAS);
    w_bias_sel = (r_state == ST_BIAS);
    w_mac_clr  = (w_accept && (r_cnt == c_CNT_LAST)) ||
                 ((r_state == ST_EMIT) && out_ready && !out_last);
    w_mac_w    = w_bias_sel ? r_b[r_j] : r_w[r_wa];
  end

  // Parameter reads above use the pre-write contents, so a same-cycle write is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w <= '{default: '0};
      r_b <= '{default: '0};
    end else if (cfg_we) begin
      if (w_is_w)      r_w[cfg_addr] <= cfg_data;
      else if (w_is_b) r_b[c_IDX_W'(cfg_addr - c_NW_S)] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           r_x <= '{default: '0};
    else if (w_accept) r_x[r_cnt] <= in_data;
  end

  nn_mac_unit #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (w_mac_en),
    .clr      (w_mac_clr),
    .bias_sel (w_bias_sel),
    .x        (r_x[r_cnt]),
    .w        (w_mac_w),
    .acc      (w_acc)
  );

  // r_wa walks the flat weight file continuously, so it lands on row j+1 after row j.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_COLLECT;
      r_cnt     <= '0;
      r_j       <= '0;
      r_wa      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (r_cnt == c_CNT_LAST) begin
              r_cnt    <= '0;
              r_j      <= '0;
              r_wa     <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              r_state  <= ST_MAC;
            end else begin
              r_cnt <= r_cnt + c_CW'(1);
            end
          end
        end
        ST_MAC: begin
          r_wa <= r_wa + c_AW'(1);
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_BIAS;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        ST_BIAS: r_state <= ST_ACT;
        ST_ACT: begin
          out_data  <= DW'(sat_to_dw(32'(w_acc), DW, ACT == ACT_RELU));
          out_idx   <= r_j;
          out_last  <= (r_j == c_J_LAST);
          out_valid <= 1'b1;
          r_state   <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              r_state  <= ST_COLLECT;
            end else begin
              r_j     <= r_j + c_IDX_W'(1);
              r_state <= ST_MAC;
            end
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nn_dense_stage.sv
// ============================================================================
// Module      : tb_nn_dense_stage
// Description : Scoreboard bench driving a ReLU and an identity instance in
//               lockstep with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_dense_stage;

  localparam int N_IN = 2;

  typedef struct {
    int d;
    int idx;
    int last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_rdy = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;

  logic       ir [2];
  logic       ov [2];
  logic [7:0] od [2];
  logic       oi [2];
  logic       ol [2];
  logic       bz [2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_dense_stage #(.N_IN(2), .N_OUT(2), .DW(8), .FRAC(4), .ACC_W(20), .ACT(0)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_idx(oi[0]), .out_last(ol[0]),
    .out_ready(out_rdy), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(bz[0])
  );

  nn_dense_stage #(.N_IN(2), .N_OUT(2), .DW(8), .FRAC(4), .ACC_W(20), .ACT(1)) u_ident (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_idx(oi[1]), .out_last(ol[1]),
    .out_ready(out_rdy), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(bz[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 8'(d);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic send_sample(input int x);
    int n;
    n = 0;
    while (!ir[0] && n < 200) begin
      tick();
      n++;
    end
    if (!ir[0]) begin
      chk("in_ready_timeout", int'(ir[0]), 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = 8'(x);
    acc_cyc  = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input int r0, input int r1, input int i0, input int i1);
    q0.push_back('{d: r0, idx: 0, last: 0});
    q0.push_back('{d: r1, idx: 1, last: 1});
    q1.push_back('{d: i0, idx: 0, last: 0});
    q1.push_back('{d: i1, idx: 1, last: 1});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 300) begin
      tick();
      n++;
    end
    if ((q0.size() + q1.size()) != 0) chk("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  // Monitor: scoreboard pops on handshake plus hold/handshake protocol checks.
  initial begin
    logic       stall [2];
    logic       pv    [2];
    logic       plast [2];
    logic [7:0] hd    [2];
    logic       hi    [2];
    logic       hl    [2];
    exp_t       e;
    for (int k = 0; k < 2; k++) begin
      stall[k] = 1'b0; pv[k] = 1'b0; plast[k] = 1'b0;
      hd[k] = '0; hi[k] = 1'b0; hl[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          stall[k] = 1'b0; pv[k] = 1'b0; plast[k] = 1'b0;
        end else begin
          if (stall[k]) begin
            chk($sformatf("d%0d_hold_valid", k), int'(ov[k]), 1);
            chk($sformatf("d%0d_hold_data", k), int'(od[k]), int'(hd[k]));
            chk($sformatf("d%0d_hold_idx_last", k), int'({oi[k], ol[k]}), int'({hi[k], hl[k]}));
          end
          if (plast[k]) chk($sformatf("d%0d_in_ready_after_last", k), int'(ir[k]), 1);
          plast[k] = 1'b0;
          if (ov[k]) begin
            chk($sformatf("d%0d_in_ready_low", k), int'(ir[k]), 0);
            chk($sformatf("d%0d_busy_high", k), int'(bz[k]), 1);
            if (!pv[k] && !oi[k]) chk($sformatf("d%0d_latency", k), cyc - acc_cyc, N_IN + 3);
          end
          if (ov[k] && out_rdy) begin
            if ((k == 0 ? q0.size() : q1.size()) == 0) begin
              chk($sformatf("d%0d_unexpected_output", k), $signed(od[k]), -999);
            end else begin
              if (k == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk($sformatf("d%0d_out_data", k), $signed(od[k]), e.d);
              chk($sformatf("d%0d_out_idx", k), int'(oi[k]), e.idx);
              chk($sformatf("d%0d_out_last", k), int'(ol[k]), e.last);
            end
            if (ol[k]) plast[k] = 1'b1;
          end
          stall[k] = ov[k] && !out_rdy;
          hd[k] = od[k]; hi[k] = oi[k]; hl[k] = ol[k];
          pv[k] = ov[k];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_rst_in_ready", k), int'(ir[k]), 1);
      chk($sformatf("d%0d_rst_out_valid", k), int'(ov[k]), 0);
      chk($sformatf("d%0d_rst_out_data", k), int'(od[k]), 0);
      chk($sformatf("d%0d_rst_out_idx_last", k), int'({oi[k], ol[k]}), 0);
      chk($sformatf("d%0d_rst_busy", k), int'(bz[k]), 0);
    end

    cfg_wr(0, 26); cfg_wr(1, -25); cfg_wr(2, 127); cfg_wr(3, 127);
    cfg_wr(4, 34); cfg_wr(5, 0);
    cfg_wr(6, 99); cfg_wr(7, -99);

    push_exp(61, 127, 61, 127);
    send_sample(32); send_sample(16);
    drain();

    push_exp(41, 127, 41, 127);
    send_sample(127); send_sample(127);
    drain();

    // Backpressure on neuron 0 for five cycles
    out_rdy = 1'b0;
    push_exp(0, 127, -66, 127);
    send_sample(0); send_sample(64);
    n = 0;
    while (!ov[0] && n < 50) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", int'(ov[0]), 1);
    repeat (5) tick();
    out_rdy = 1'b1;
    drain();

    // Overwrite w[0][1] in the very cycle its term is accumulated
    push_exp(61, 127, 61, 127);
    send_sample(32); send_sample(16);
    tick();
    cfg_wr(1, 0);
    drain();

    push_exp(86, 127, 86, 127);
    send_sample(32); send_sample(16);
    drain();

    cfg_wr(0, -25); cfg_wr(1, 0); cfg_wr(4, 0);
    cfg_wr(2, -128); cfg_wr(3, -128); cfg_wr(5, -128);

    push_exp(0, 0, -27, -128);
    send_sample(17); send_sample(0);
    drain();

    push_exp(26, 8, 26, 8);
    send_sample(-17); send_sample(0);
    drain();

    // Reset while the MAC is running
    send_sample(32); send_sample(16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_midrst_in_ready", k), int'(ir[k]), 1);
      chk($sformatf("d%0d_midrst_out_valid", k), int'(ov[k]), 0);
      chk($sformatf("d%0d_midrst_busy", k), int'(bz[k]), 0);
    end

    push_exp(0, 0, 0, 0);
    send_sample(32); send_sample(16);
    drain();
    tick();
    chk("final_idle_in_ready", int'(ir[0] & ir[1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nn_dense_stage.md
Name: nn_dense_stage

Overview:
- Fully-connected neuron stage that sits directly downstream of a single-neuron layer.
- Collects N_IN signed Q4.4 activations serially from the upstream layer.
- Computes N_OUT neurons with one MAC unit (bias add, then activation).
- Emits results serially under valid/ready backpressure. Weights and biases are runtime-loadable through a config write port.

Parameters:
N_IN, 2, inputs per neuron (>=1)
N_OUT, 2, neurons computed per input vector (>=1)
DW, 8, signed data/weight/bias width
FRAC, 4, fractional bits (Q(DW-FRAC).FRAC)
ACC_W, 20, signed accumulator width
ACT, 0, 0 = ReLU with saturation to [0,2^(DW-1)-1]; 1 = identity with saturation to signed DW range

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream activation valid
in_data  in  DW  signed activation
in_ready  out  1  stage accepts activation
out_valid  out  1  result valid
out_data  out  DW  signed neuron result
out_idx  out  clog2(N_OUT) (min 1)  neuron index of out_data
out_last  out  1  out_data is neuron N_OUT-1
out_ready  in  1  downstream accepts result
cfg_we  in  1  parameter write strobe
cfg_addr  in  clog2(N_OUT*N_IN+N_OUT)  parameter address
cfg_data  in  DW  signed weight/bias value
busy  out  1  high in any state except COLLECT

Behaviour:
- Reset clears the following: state=COLLECT, input count=0, neuron index j=0, acc=0, all weights and biases=0. Outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
- Reset mid-operation aborts immediately. Any partial vector and result are discarded, and parameters are cleared.
- Config port:
  - addr a < N_OUT*N_IN writes weight[a/N_IN][a%N_IN].
  - a in [N_OUT*N_IN, N_OUT*N_IN+N_OUT) writes bias[a-N_OUT*N_IN].
  - Other addresses are ignored.
  - Writes are accepted in any state and take effect the next cycle. A MAC read in the same cycle as a write to the same address sees the old value.
- COLLECT:
  - in_ready=1; each cycle with in_valid&in_ready stores in_data into x[count] and increments count.
  - Accepting the N_IN-th sample sets count=0, j=0, acc=0 and goes to MAC.
- MAC:
  - in_ready=0; one term per cycle, i=0..N_IN-1.
  - Term = (x[i]*w[j][i]), full 2*DW signed product, arithmetic shift right by FRAC (floor), sign-extended to ACC_W; acc+=term, wrapping mod 2^ACC_W.
  - After N_IN cycles go to BIAS.
- BIAS: acc += sign-extended bias[j] (same Q format, no shift). 1 cycle, then ACT.
- ACT: apply activation and saturation to acc, register into out_data, set out_idx=j and out_last=(j==N_OUT-1). 1 cycle, then EMIT.
- EMIT:
  - out_valid=1; out_data/out_idx/out_last stay stable until out_ready.
  - On handshake: if last, go to COLLECT (in_ready=1 next cycle); else j++, acc=0, go to MAC.
- Latency: last input accepted at cycle t gives first out_valid at t+N_IN+3. Each further neuron follows N_IN+2 cycles after the previous handshake.
- Throughput: no input overlap. in_ready=0 from the cycle after the final accept until the final output handshake.
- out_valid never drops without a handshake. in_valid while in_ready=0 is ignored (upstream holds).

Decomposition:
- Shared package nn_pkg holds DW/FRAC defaults, the activation-mode constants (ACT_RELU=0, ACT_IDENT=1), the state encoding (COLLECT, MAC, BIAS, ACT, EMIT), and a sat_to_dw function.
- One natural sub-module: nn_mac_unit, which holds the product, shift, accumulate and clear (registered acc, inputs x/w/en/clr). The FSM, register files and handshake stay in the top level.

Test Plan:
- Basic MAC, defaults, N_OUT=1 neuron 0:
  - Config: w0=26, w1=-25, b=34. Send x=32, x=16.
  - Terms are 52 and -25 (floor of -400/16). Expect out_data=61, out_idx=0, out_last=1.
  - First out_valid exactly N_IN+3=5 cycles after the last accept.
- Saturation and ReLU:
  - w=127,127, b=0, x=127,127 → 127.
  - w=26,-25, b=34, x=0,64 → -66 → 0 (ACT=0); with ACT=1 → -66.
- Floor rounding: w0=-25, w1=0, b=0, x0=17 → -27 (not -26).
- N_OUT=2 with backpressure:
  - Hold out_ready=0 for 5 cycles on neuron 0: out_valid/out_data stay stable and in_ready=0.
  - After release, neuron 1 appears with out_last=1. in_ready rises only after its handshake.
- Config hazard: write w[0][1] in the same cycle its MAC term is read → the old weight is used. The next vector uses the new weight.
- Reset mid-MAC:
  - Assert rst during MAC → the next cycle gives in_ready=1, out_valid=0, busy=0, params 0.
  - Re-run basic vector without config → 0.
